mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one external single-port memory bus between the `rv32e_core` instruction-fetch port and data port. Core requests are accepted through a stall/valid handshake and turned into one request/ready transaction at a time on the shared bus. Data accesses and fetches are granted in alternation when both are pending, so neither side starves. The block sits between the core and the memory/flash controller in the SoC top.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, level; held stable by core while `stall`=1.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched word; held until the next fetch completes.
- `if_valid` out 1: one-cycle pulse, fetch complete.
- `d_re` / `d_we` in 1: data read / write request, level; held stable while `stall`=1.
- `d_addr` in ADDR_W, `d_wdata` in DATA_W: data address / write data.
- `d_rdata` out DATA_W: read word; held until the next data read completes.
- `d_valid` out 1: one-cycle pulse, data access (read or write) complete.
- `stall` out 1: core must hold its state.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out ADDR_W, `bus_wdata` out DATA_W: shared-bus request.
- `bus_ready` in 1: bus completes the current transaction this cycle.
- `bus_rdata` in DATA_W: read data, valid when `bus_ready`=1.

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- Eligibility in IDLE:
  - Data is eligible when `(d_re|d_we) & ~d_valid`.
  - Fetch is eligible when `if_req & ~if_valid`.
  - The valid term blocks re-granting a request the core is retiring this cycle.
- Grant:
  - Only one side eligible: grant it.
  - Both eligible: grant the side opposite `last_grant`.
  - `last_grant` resets to I, so the first contended grant goes to data.
- On grant, the state, `last_grant`, and the bus registers (`bus_addr`, `bus_wdata`, `bus_we`, `bus_req`=1) load at the clock edge.
- `bus_we` = `d_we` for data grants; `d_we` takes precedence if `d_re` and `d_we` are both high. `bus_we`=0 for fetch grants.
- BUSY_x:
  - Bus outputs are held constant until `bus_ready`=1.
  - On that edge: `bus_req`→0, state→IDLE, and the matching `x_valid`→1 for exactly one cycle.
  - Read data is captured into `if_rdata` or `d_rdata`. A write leaves `d_rdata` unchanged.
- `bus_ready` is ignored in IDLE.
- `stall` (combinational) = `((d_re|d_we) & ~d_valid) | (if_req & ~if_valid)`.
- Requests are not latched from the core during BUSY. Address changes while stalled are a core protocol violation.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `if_valid`=0, `d_valid`=0, `if_rdata`=0, `d_rdata`=0, state=IDLE, `last_grant`=I.
- `stall` follows its inputs during reset.
- Latency, request seen in cycle N, zero-wait bus:
  - `bus_req` high in cycle N+1.
  - `bus_ready` in cycle N+1.
  - `x_valid` high in cycle N+2.
- Each bus wait cycle adds 1 to this latency.
- Back-to-back: the next grant is sampled in the valid cycle, so `bus_req` is high again in N+3. The minimum is 2 cycles per access.
- `bus_req` is never high for more than one transaction without an intervening IDLE cycle.
- Reset asserted mid-transaction: all outputs go to reset values immediately. The transaction is abandoned and no valid is issued.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY_D, BUSY_I}.
  - `grant_t` enum {GRANT_I, GRANT_D}.
  - Reset-value constants.
- Single module, no sub-modules. The grant logic is small enough to inline.

## Test plan
- Fetch only, zero-wait: `if_req`=1, `if_addr`=0x100, `bus_rdata`=0x00500093 → `bus_req` at N+1 with `bus_addr`=0x100, `bus_we`=0; `if_valid` at N+2 with `if_rdata`=0x00500093; `stall`=1 in N and N+1, 0 in N+2.
- Data write, 3 wait cycles: `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF → `bus_we`=1, `bus_wdata`=0xDEADBEEF held 4 cycles; `d_valid` one cycle later; `d_rdata` unchanged.
- Contention: `if_req` and `d_re` both high from reset → data granted first (`bus_addr`=`d_addr`), then fetch. `stall` stays 1 until both valids have pulsed.
- Alternation: both requesting continuously with new addresses after each valid for 8 accesses → grants D, I, D, I…; no request is granted twice for the same valid.
- Reset mid-operation: drop `rst_n` while in BUSY_D with `bus_ready`=0 → `bus_req`=0 in the same cycle and no `d_valid`. After release, a fresh `d_re` completes normally.
- Read while simultaneously writing: `d_re`=`d_we`=1 → `bus_we`=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and reset constants for mem_port_arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY_D, BUSY_I)
//   grant_t     : which core port owned the most recent bus grant
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    // Reset values. Starting last_grant at I means the first contended
    // grant after reset goes to the data port.
    localparam arb_state_t STATE_RST      = IDLE;
    localparam grant_t     LAST_GRANT_RST = GRANT_I;
    localparam logic       BUS_REQ_RST    = 1'b0;
    localparam logic       BUS_WE_RST     = 1'b0;
    localparam logic       VALID_RST      = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: shared single-port memory bus.
//   bus_req/bus_we/bus_addr/bus_wdata : request, driven by the arbiter
//   bus_ready                         : transaction completes this cycle
//   bus_rdata                         : read data, valid with bus_ready
// Modports: master (arbiter side), slave (memory/flash controller side).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between the core's
// instruction-fetch port and data port, one transaction at a time.
//   clk, rst_n          : clock, async active-low reset
//   if_req/if_addr      : fetch request (level) and address
//   if_rdata/if_valid   : fetched word (held) and one-cycle completion pulse
//   d_re/d_we           : data read/write request (level)
//   d_addr/d_wdata      : data address / write data
//   d_rdata/d_valid     : read word (held) and one-cycle completion pulse
//   stall               : core must hold its state
//   bus                 : shared bus, master side
// When both ports are pending the grant alternates, so neither starves.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_re,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                stall,
    mem_port_arbiter_if.master  bus
);

    arb_state_t state;
    grant_t     last_grant;

    logic d_pend;
    logic i_pend;
    logic grant_d;
    logic grant_i;

    // A port whose valid is high this cycle is retiring its request; the
    // core still holds the old request level, so it must not be re-granted.
    always_comb begin
        d_pend  = (d_re | d_we) & ~d_valid;
        i_pend  = if_req & ~if_valid;
        stall   = d_pend | i_pend;
        grant_d = d_pend & (~i_pend | (last_grant == GRANT_I));
        grant_i = i_pend & ~grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= STATE_RST;
            last_grant    <= LAST_GRANT_RST;
            bus.bus_req   <= BUS_REQ_RST;
            bus.bus_we    <= BUS_WE_RST;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            if_valid      <= VALID_RST;
            d_valid       <= VALID_RST;
            if_rdata      <= '0;
            d_rdata       <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= BUSY_D;
                        last_grant    <= GRANT_D;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= d_we;  // write wins over read
                        bus.bus_addr  <= d_addr;
                        bus.bus_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state         <= BUSY_I;
                        last_grant    <= GRANT_I;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= if_addr;
                    end
                end
                BUSY_D: begin
                    if (bus.bus_ready) begin
                        state       <= IDLE;
                        bus.bus_req <= 1'b0;
                        d_valid     <= 1'b1;
                        if (!bus.bus_we)
                            d_rdata <= bus.bus_rdata;
                    end
                end
                BUSY_I: begin
                    if (bus.bus_ready) begin
                        state       <= IDLE;
                        bus.bus_req <= 1'b0;
                        if_valid    <= 1'b1;
                        if_rdata    <= bus.bus_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge; the bus side is a scripted responder.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_re, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          stall;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .d_re     (d_re),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .stall    (stall),
        .bus      (bus_if.master)
    );

    task automatic test_reset;
        rst_n = 1'b0; if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(negedge clk);
        total++; if ({bus_if.bus_req, bus_if.bus_we, if_valid, d_valid, stall} !== 5'b0) $display("FAIL rst_ctrl: got %b expected 00000", {bus_if.bus_req, bus_if.bus_we, if_valid, d_valid, stall}); else passed++;
        total++; if (bus_if.bus_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", bus_if.bus_addr); else passed++;
        total++; if (bus_if.bus_wdata !== 32'h0) $display("FAIL rst_wdata: got %h expected 0", bus_if.bus_wdata); else passed++;
        total++; if ({if_rdata, d_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h expected 0", {if_rdata, d_rdata}); else passed++;
        if_req = 1'b1; #1;
        total++; if (stall !== 1'b1) $display("FAIL rst_stall_follow: got %b expected 1", stall); else passed++;
        total++; if (bus_if.bus_req !== 1'b0) $display("FAIL rst_no_grant: got %b expected 0", bus_if.bus_req); else passed++;
        if_req = 1'b0; #1;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall_low: got %b expected 0", stall); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus_if.bus_req !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", bus_if.bus_req); else passed++;
    endtask

    task automatic test_fetch;
        if_addr = 32'h100; if_req = 1'b1; #1;
        total++; if (stall !== 1'b1) $display("FAIL fetch_stall_n: got %b expected 1", stall); else passed++;
        @(negedge clk);
        total++; if (bus_if.bus_req !== 1'b1) $display("FAIL fetch_req: got %b expected 1", bus_if.bus_req); else passed++;
        total++; if (bus_if.bus_addr !== 32'h100) $display("FAIL fetch_addr: got %h expected 100", bus_if.bus_addr); else passed++;
        total++; if (bus_if.bus_we !== 1'b0) $display("FAIL fetch_we: got %b expected 0", bus_if.bus_we); else passed++;
        total++; if ({stall, if_valid} !== 2'b10) $display("FAIL fetch_n1: got %b expected 10", {stall, if_valid}); else passed++;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h00500093;
        @(negedge clk);
        total++; if (if_valid !== 1'b1) $display("FAIL fetch_valid: got %b expected 1", if_valid); else passed++;
        total++; if (if_rdata !== 32'h00500093) $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata); else passed++;
        total++; if ({stall, bus_if.bus_req} !== 2'b00) $display("FAIL fetch_n2: got %b expected 00", {stall, bus_if.bus_req}); else passed++;
        if_req = 1'b0; bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
        @(negedge clk);
        total++; if (if_valid !== 1'b0) $display("FAIL fetch_pulse: got %b expected 0", if_valid); else passed++;
    endtask

    task automatic test_read;
        d_addr = 32'h1000; d_re = 1'b1;
        @(negedge clk);
        total++; if ({bus_if.bus_req, bus_if.bus_we} !== 2'b10) $display("FAIL read_req: got %b expected 10", {bus_if.bus_req, bus_if.bus_we}); else passed++;
        total++; if (bus_if.bus_addr !== 32'h1000) $display("FAIL read_addr: got %h expected 1000", bus_if.bus_addr); else passed++;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h11223344;
        @(negedge clk);
        total++; if ({d_valid, if_valid} !== 2'b10) $display("FAIL read_valid: got %b expected 10", {d_valid, if_valid}); else passed++;
        total++; if (d_rdata !== 32'h11223344) $display("FAIL read_rdata: got %h expected 11223344", d_rdata); else passed++;
        d_re = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_wait;
        d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({bus_if.bus_req, bus_if.bus_we, d_valid} !== 3'b110) $display("FAIL wr_ctl_%0d: got %b expected 110", i, {bus_if.bus_req, bus_if.bus_we, d_valid}); else passed++;
            total++; if (bus_if.bus_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata_%0d: got %h expected deadbeef", i, bus_if.bus_wdata); else passed++;
            total++; if (bus_if.bus_addr !== 32'h2000) $display("FAIL wr_addr_%0d: got %h expected 2000", i, bus_if.bus_addr); else passed++;
            if (i == 3) begin
                bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hBAD0BAD0;
            end
        end
        @(negedge clk);
        total++; if (d_valid !== 1'b1) $display("FAIL wr_valid: got %b expected 1", d_valid); else passed++;
        total++; if (d_rdata !== 32'h11223344) $display("FAIL wr_rdata_kept: got %h expected 11223344", d_rdata); else passed++;
        d_we = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++; if (d_valid !== 1'b0) $display("FAIL wr_pulse: got %b expected 0", d_valid); else passed++;
    endtask

    task automatic test_contention;
        rst_n = 1'b0; if_addr = 32'h200; if_req = 1'b1; d_addr = 32'h3000; d_re = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus_if.bus_addr !== 32'h3000) $display("FAIL cont_first_d: got %h expected 3000", bus_if.bus_addr); else passed++;
        total++; if ({bus_if.bus_req, stall} !== 2'b11) $display("FAIL cont_req1: got %b expected 11", {bus_if.bus_req, stall}); else passed++;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hD1;
        @(negedge clk);
        total++; if ({d_valid, stall, bus_if.bus_req} !== 3'b110) $display("FAIL cont_dvalid: got %b expected 110", {d_valid, stall, bus_if.bus_req}); else passed++;
        total++; if (d_rdata !== 32'hD1) $display("FAIL cont_drdata: got %h expected d1", d_rdata); else passed++;
        d_re = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clk);
        total++; if (bus_if.bus_addr !== 32'h200) $display("FAIL cont_then_i: got %h expected 200", bus_if.bus_addr); else passed++;
        total++; if ({bus_if.bus_req, stall} !== 2'b11) $display("FAIL cont_req2: got %b expected 11", {bus_if.bus_req, stall}); else passed++;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hF1;
        @(negedge clk);
        total++; if ({if_valid, stall} !== 2'b10) $display("FAIL cont_ivalid: got %b expected 10", {if_valid, stall}); else passed++;
        total++; if (if_rdata !== 32'hF1) $display("FAIL cont_irdata: got %h expected f1", if_rdata); else passed++;
        if_req = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alternation;
        int d_cnt = 0;
        int i_cnt = 0;
        logic          exp_d;
        logic [AW-1:0] exp_addr;
        d_addr = 32'h3000; if_addr = 32'h400; d_re = 1'b1; if_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int waited = 0;
            exp_d = (k % 2 == 0);
            @(negedge clk);
            while (bus_if.bus_req !== 1'b1 && waited < 5) begin
                @(negedge clk); waited++;
            end
            total++; if (bus_if.bus_req !== 1'b1) $display("FAIL alt_req_%0d: got %b expected 1", k, bus_if.bus_req); else passed++;
            exp_addr = exp_d ? 32'h3000 + 32'(d_cnt * 4) : 32'h400 + 32'(i_cnt * 4);
            total++; if (bus_if.bus_addr !== exp_addr) $display("FAIL alt_addr_%0d: got %h expected %h", k, bus_if.bus_addr, exp_addr); else passed++;
            bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hA0000000 | 32'(k);
            @(negedge clk);
            bus_if.bus_ready = 1'b0;
            total++; if ({d_valid, if_valid, bus_if.bus_req} !== {exp_d, ~exp_d, 1'b0}) $display("FAIL alt_valid_%0d: got %b expected %b", k, {d_valid, if_valid, bus_if.bus_req}, {exp_d, ~exp_d, 1'b0}); else passed++;
            if (exp_d) begin
                d_cnt++; d_addr = 32'h3000 + 32'(d_cnt * 4);
            end else begin
                i_cnt++; if_addr = 32'h400 + 32'(i_cnt * 4);
            end
        end
        d_re = 1'b0; if_req = 1'b0;
        @(negedge clk);
        total++; if (bus_if.bus_req !== 1'b0) $display("FAIL alt_quiet: got %b expected 0", bus_if.bus_req); else passed++;
    endtask

    task automatic test_rw;
        d_addr = 32'h44; d_wdata = 32'h5A5A5A5A; d_re = 1'b1; d_we = 1'b1;
        @(negedge clk);
        total++; if ({bus_if.bus_req, bus_if.bus_we} !== 2'b11) $display("FAIL rw_we: got %b expected 11", {bus_if.bus_req, bus_if.bus_we}); else passed++;
        total++; if (bus_if.bus_wdata !== 32'h5A5A5A5A) $display("FAIL rw_wdata: got %h expected 5a5a5a5a", bus_if.bus_wdata); else passed++;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hBAD;
        @(negedge clk);
        total++; if (d_valid !== 1'b1) $display("FAIL rw_valid: got %b expected 1", d_valid); else passed++;
        total++; if (d_rdata !== 32'hA0000006) $display("FAIL rw_rdata_kept: got %h expected a0000006", d_rdata); else passed++;
        d_re = 1'b0; d_we = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        d_addr = 32'h80; d_re = 1'b1;
        @(negedge clk);
        total++; if (bus_if.bus_req !== 1'b1) $display("FAIL rm_busy: got %b expected 1", bus_if.bus_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus_if.bus_req !== 1'b0) $display("FAIL rm_req_drop: got %b expected 0", bus_if.bus_req); else passed++;
        total++; if (bus_if.bus_addr !== 32'h0) $display("FAIL rm_addr_clr: got %h expected 0", bus_if.bus_addr); else passed++;
        total++; if ({d_rdata, stall} !== {32'h0, 1'b1}) $display("FAIL rm_rdata_stall: got %h expected 000000001", {d_rdata, stall}); else passed++;
        bus_if.bus_ready = 1'b1;
        @(negedge clk);
        total++; if (d_valid !== 1'b0) $display("FAIL rm_no_valid: got %b expected 0", d_valid); else passed++;
        bus_if.bus_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        total++; if ({bus_if.bus_req, d_valid} !== 2'b10) $display("FAIL rm_regrant: got %b expected 10", {bus_if.bus_req, d_valid}); else passed++;
        total++; if (bus_if.bus_addr !== 32'h80) $display("FAIL rm_addr: got %h expected 80", bus_if.bus_addr); else passed++;
        bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h77;
        @(negedge clk);
        total++; if ({d_valid, d_rdata} !== {1'b1, 32'h77}) $display("FAIL rm_complete: got %h expected 100000077", {d_valid, d_rdata}); else passed++;
        d_re = 1'b0; bus_if.bus_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_read();
        test_write_wait();
        test_contention();
        test_alternation();
        test_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
